riscv_ahb3lite_sram: RTL

AHB3-Lite slave (responder) backed by a single-port on-chip SRAM array. It is the bus-far end for the core's BIU-to-AHB master and serves as tightly-coupled or boot memory in the MPSoC. It accepts single and burst transfers, inserts programmable wait states, generates the two-cycle ERROR response, and forwards same-word write data to a back-to-back read.

---
 rtl/riscv_ahb3lite_sram.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/riscv_ahb3lite_sram.sv
// AHB3-Lite responder in front of a single-port SRAM, with wait states, a two-cycle ERROR
// response and write-to-read forwarding. Define RISCV_AHB3_SRAM_WRPROT_EN to reject user writes.
module riscv_ahb3lite_sram #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned PLEN        = 64,
  parameter int unsigned MEM_SIZE    = 4096,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned AW    = $clog2(MEM_SIZE);
  localparam int unsigned BW    = $clog2(NB);
  localparam int unsigned WW    = AW - BW;
  localparam int unsigned DEPTH = MEM_SIZE / NB;

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            hreadyout_q, hreadyout_d;
  logic            hresp_q, hresp_d;
  logic [XLEN-1:0] hrdata_q, hrdata_d;
  logic            dp_valid_q, dp_valid_d;
  logic            dp_write_q, dp_write_d;
  logic [WW-1:0]   dp_word_q, dp_word_d;
  logic [NB-1:0]   dp_be_q, dp_be_d;

  logic [XLEN-1:0] mem [DEPTH];

  logic            accept, addr_err, size_err, align_err, prot_err, xfer_err, commit;
  logic [WW-1:0]   word;
  logic [BW-1:0]   lane, align_mask;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] rd_word;
  logic            unused_ok;

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign word     = HADDR[AW-1:BW];
  assign lane     = HADDR[BW-1:0];
  assign addr_err = |HADDR[PLEN-1:AW];
  assign size_err = 32'(HSIZE) > BW;
  assign align_mask = BW'((32'd1 << HSIZE) - 32'd1);
  assign align_err  = |(lane & align_mask);

`ifdef RISCV_AHB3_SRAM_WRPROT_EN
  assign prot_err = HWRITE & ~HPROT[1];
`else
  assign prot_err = 1'b0;
`endif

  assign xfer_err  = addr_err | size_err | align_err | prot_err;
  assign unused_ok = ^{HBURST, HMASTLOCK, HPROT, HTRANS[0]};

  // A lane is enabled when it falls in the same naturally aligned HSIZE block as the address.
  always_comb begin
    be = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      be[b] = (b >> HSIZE) == (32'(lane) >> HSIZE);
    end
  end

  // The write data phase ends on the same edge a following read is accepted: forward its lanes.
  assign commit = dp_valid_q & dp_write_q & hreadyout_q & HRESETn;

  always_comb begin
    rd_word = mem[word];
    if (commit && dp_word_q == word) begin
      for (int b = 0; b < NB; b++) begin
        if (dp_be_q[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    hrdata_d    = hrdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_word_d   = dp_word_q;
    dp_be_d     = dp_be_q;
    case (state_q)
      StIdle, StErr2: begin
        state_d    = StIdle;
        dp_valid_d = 1'b0;
        if (accept) begin
          if (xfer_err) begin
            state_d     = StErr1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
          end else begin
            dp_valid_d = 1'b1;
            dp_write_d = HWRITE;
            dp_word_d  = word;
            dp_be_d    = be;
            if (!HWRITE) hrdata_d = rd_word;
            if (WAIT_STATES != 0) begin
              state_d     = StWait;
              cnt_d       = 4'(WAIT_STATES);
              hreadyout_d = 1'b0;
            end
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StIdle;
        else hreadyout_d = 1'b0;
      end
      StErr1: begin
        state_d = StErr2;
        hresp_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_word_q   <= '0;
      dp_be_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_word_q   <= dp_word_d;
      dp_be_q     <= dp_be_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (dp_be_q[b]) mem[dp_word_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule
